// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule, one round key per clock, with an 11-entry key table
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, key_in         expansion request (honoured in IDLE) and cipher key, w0 = key_in[127:96]
//   round_key, rk_idx     registered round key stream and its round index
//   rk_valid, busy, done  stream valid, expansion in progress, pulse with round key NR
//   keys_ready            table holds a complete schedule
//   rd_idx, rd_key        table read port, 1-cycle latency, out-of-range reads return 0
module aes_rcon (
  input  logic [3:0]  i_rnd_no,
  output logic [31:0] o_rcon
);
  always_comb begin
    o_rcon = '0;
    case (i_rnd_no)
      4'd1:  o_rcon = 32'h0100_0000;
      4'd2:  o_rcon = 32'h0200_0000;
      4'd3:  o_rcon = 32'h0400_0000;
      4'd4:  o_rcon = 32'h0800_0000;
      4'd5:  o_rcon = 32'h1000_0000;
      4'd6:  o_rcon = 32'h2000_0000;
      4'd7:  o_rcon = 32'h4000_0000;
      4'd8:  o_rcon = 32'h8000_0000;
      4'd9:  o_rcon = 32'h1b00_0000;
      4'd10: o_rcon = 32'h3600_0000;
      default: o_rcon = '0;
    endcase
  end
endmodule

module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] round_key,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic         busy,
  output logic         done,
  output logic         keys_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);
  localparam logic [3:0] LAST = 4'(NR);
  // FIPS-197 S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic {S_IDLE, S_EXPAND} state_t;
  state_t       r_state;
  logic [3:0]   r_rnd;
  logic [127:0] r_table [0:NR];
  logic [31:0]  w_rcon, w_rot, w_temp, w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_next;
  // byte x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  aes_rcon u_rcon (
    .i_rnd_no (r_rnd),
    .o_rcon   (w_rcon)
  );
  always_comb begin
    w_rot  = {round_key[23:0], round_key[31:24]};
    w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])} ^ w_rcon;
    w_n0   = round_key[127:96] ^ w_temp;
    w_n1   = round_key[95:64] ^ w_n0;
    w_n2   = round_key[63:32] ^ w_n1;
    w_n3   = round_key[31:0] ^ w_n2;
    w_next = {w_n0, w_n1, w_n2, w_n3};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rnd      <= '0;
      round_key  <= '0;
      rk_idx     <= '0;
      rk_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_ready <= 1'b0;
      rd_key     <= '0;
      for (int i = 0; i <= NR; i++) r_table[i] <= '0;
    end else begin
      rd_key   <= (rd_idx <= LAST) ? r_table[rd_idx] : '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            round_key  <= key_in;
            rk_idx     <= '0;
            rk_valid   <= 1'b1;
            r_table[0] <= key_in;
            r_rnd      <= 4'd1;
            keys_ready <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          round_key      <= w_next;
          rk_idx         <= r_rnd;
          rk_valid       <= 1'b1;
          r_table[r_rnd] <= w_next;
          r_rnd          <= r_rnd + 4'd1;
          if (r_rnd == LAST) begin
            done       <= 1'b1;
            keys_ready <= 1'b1;
            busy       <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: scoreboard bench for aes_key_expand with an independently derived key-schedule model
module tb_aes_key_expand;
  typedef struct packed {
    logic [127:0] key;
    logic [3:0]   idx;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] round_key, rd_key;
  logic [3:0]   rk_idx;
  logic         rk_valid, busy, done, keys_ready;
  logic [3:0]   rd_idx = '0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   sb [256];
  logic [7:0]   rc [11];
  logic [127:0] sched [11];
  logic [127:0] keys [4];
  exp_t         sb_q [$];
  logic [127:0] rq [$];

  aes_key_expand dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .round_key  (round_key),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .busy       (busy),
    .done       (done),
    .keys_ready (keys_ready),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_tables;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h00;
    rc[1] = 8'h01;
    for (int i = 2; i < 11; i++) rc[i] = gmul(rc[i-1], 8'h02);
  endtask

  function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc[r], 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic push_sched(input logic [127:0] key);
    sched[0] = key;
    for (int r = 1; r < 11; r++) sched[r] = next_key(sched[r-1], r);
    for (int r = 0; r < 11; r++) sb_q.push_back('{key: sched[r], idx: 4'(r)});
  endtask

  task automatic expand(input int runs, input bit hold, input int poke,
                        output logic [127:0] k1, output logic [127:0] k10);
    exp_t e;
    int run, ndone, nvalid;
    ndone = 0;
    nvalid = 0;
    k1 = '0;
    k10 = '0;
    @(negedge clk);
    start = 1'b1;
    key_in = keys[0];
    push_sched(keys[0]);
    run = 1;
    for (int c = 0; c < 11 * runs + 5 && sb_q.size() > 0; c++) begin
      @(negedge clk);
      start = hold && run < runs;
      n_vec++;
      if (!rk_valid) begin
        n_err++;
        $display("FAIL stream_gap: rk_valid=%b required 1 at cycle %0d", rk_valid, c);
      end else begin
        e = sb_q.pop_front();
        nvalid++;
        if (rk_idx == 4'd1) k1 = round_key;
        if (done) ndone++;
        n_vec++;
        if ({rk_idx, round_key} !== {e.idx, e.key}) begin
          n_err++;
          $display("FAIL round_key: idx=%0d key=%h required idx=%0d key=%h", rk_idx, round_key, e.idx, e.key);
        end
        n_vec++;
        if ({busy, done, keys_ready} !== {e.idx != 4'd10, e.idx == 4'd10, e.idx == 4'd10}) begin
          n_err++;
          $display("FAIL flags idx=%0d: busy/done/keys_ready=%b%b%b required %b%b%b", e.idx, busy, done,
                   keys_ready, e.idx != 4'd10, e.idx == 4'd10, e.idx == 4'd10);
        end
        if (e.idx == 4'd10) begin
          k10 = round_key;
          if (run < runs) begin
            start = 1'b1;
            key_in = keys[run];
            push_sched(keys[run]);
            run++;
          end
        end
      end
      if (poke >= 0 && rk_valid && rk_idx == 4'(poke)) begin
        start = 1'b1;
        key_in = ~keys[run-1];
      end
    end
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_timeout: %0d keys outstanding required 0", sb_q.size());
      sb_q.delete();
    end
    n_vec++;
    if (ndone != runs || nvalid != 11 * runs) begin
      n_err++;
      $display("FAIL counts: done=%0d valid=%0d required done=%0d valid=%0d", ndone, nvalid, runs, 11 * runs);
    end
    start = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({rk_valid, busy, done, keys_ready, rk_idx, round_key} !== {4'b0001, 4'd10, k10}) begin
      n_err++;
      $display("FAIL idle_after: v/b/d/kr=%b%b%b%b idx=%0d key=%h required 0001 idx=10 key=%h",
               rk_valid, busy, done, keys_ready, rk_idx, round_key, k10);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({round_key, rk_idx, rk_valid, busy, done, keys_ready, rd_key} !== '0) begin
      n_err++;
      $display("FAIL reset: key=%h idx=%0d v/b/d/kr=%b%b%b%b rd_key=%h required all 0",
               round_key, rk_idx, rk_valid, busy, done, keys_ready, rd_key);
    end
    rst = 1'b0;
  endtask

  task automatic test_fips;
    logic [127:0] k1, k10;
    keys[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(1, 1'b0, -1, k1, k10);
    n_vec++;
    if (k1 !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      n_err++;
      $display("FAIL fips_idx1: got %h required a0fafe1788542cb123a339392a6c7605", k1);
    end
    n_vec++;
    if (k10 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_err++;
      $display("FAIL fips_idx10: got %h required d014f9a8c9ee2589e13f0cc8b6630ca6", k10);
    end
  endtask

  task automatic test_read_sweep;
    logic [127:0] e;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (rq.size() > 0) begin
        e = rq.pop_front();
        n_vec++;
        if (rd_key !== e) begin
          n_err++;
          $display("FAIL rd_key idx=%0d: got %h required %h", i - 1, rd_key, e);
        end
      end
      if (i < 16) begin
        rd_idx = 4'(i);
        rq.push_back(i <= 10 ? sched[i] : 128'h0);
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic [127:0] k1, k10;
    keys[0] = {$urandom, $urandom, $urandom, $urandom};
    expand(1, 1'b0, 4, k1, k10);
    repeat (2) @(negedge clk);
    n_vec++;
    if ({rk_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL no_restart: rk_valid=%b busy=%b required 00", rk_valid, busy);
    end
  endtask

  task automatic test_reset_mid;
    logic [127:0] k1, k10;
    bit hit = 1'b0;
    @(negedge clk);
    start = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (rk_valid && rk_idx == 4'd6) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL reach_idx6: idx=%0d required 6", rk_idx);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({round_key, rk_idx, rk_valid, busy, done, keys_ready, rd_key} !== '0) begin
      n_err++;
      $display("FAIL async_reset: key=%h idx=%0d v/b/d/kr=%b%b%b%b rd_key=%h required all 0",
               round_key, rk_idx, rk_valid, busy, done, keys_ready, rd_key);
    end
    @(negedge clk);
    rst = 1'b0;
    rd_idx = 4'd3;
    @(negedge clk);
    rd_idx = 4'd10;
    n_vec++;
    if (rd_key !== '0) begin
      n_err++;
      $display("FAIL table_clear idx3: got %h required 0", rd_key);
    end
    @(negedge clk);
    n_vec++;
    if ({rd_key, rk_valid, busy} !== '0) begin
      n_err++;
      $display("FAIL table_clear idx10: rd_key=%h v=%b b=%b required 0", rd_key, rk_valid, busy);
    end
    keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
    expand(1, 1'b0, -1, k1, k10);
    n_vec++;
    if (k10 !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin
      n_err++;
      $display("FAIL key2_idx10: got %h required 13111d7fe3944a17f307a78b4d2b30c5", k10);
    end
  endtask

  task automatic test_restart_after_done;
    logic [127:0] k1, k10;
    keys[0] = {$urandom, $urandom, $urandom, $urandom};
    keys[1] = {$urandom, $urandom, $urandom, $urandom};
    expand(2, 1'b0, -1, k1, k10);
  endtask

  task automatic test_back_to_back;
    logic [127:0] k1, k10;
    for (int i = 0; i < 3; i++) keys[i] = {$urandom, $urandom, $urandom, $urandom};
    expand(3, 1'b1, -1, k1, k10);
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_read_sweep();
    test_start_while_busy();
    test_reset_mid();
    test_restart_after_done();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key-expansion engine; sits directly downstream of aes_rcon and drives its rndNo input from an internal round counter.
- Produces one 128-bit round key per clock, rounds 0..10, streamed to the cipher datapath.
- Stores all 11 round keys in an on-chip table; the inverse cipher reads that table back in any order.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is legal; it bounds the round counter and the key table depth (NR+1 entries).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to expand key_in; honoured only in IDLE.
- key_in  input  128  cipher key; sampled on the start edge; word w0 = [127:96].
- round_key  output  128  current round key, registered.
- rk_idx  output  4  round index of round_key.
- rk_valid  output  1  round_key/rk_idx valid this cycle.
- busy  output  1  high while in EXPAND.
- done  output  1  one-cycle pulse, coincident with round key 10.
- keys_ready  output  1  table holds a complete schedule.
- rd_idx  input  4  table read index.
- rd_key  output  128  table entry rd_idx, registered, 1-cycle latency.

Behaviour:
- Reset: every output and all state clear to 0; state is IDLE; the table clears to 0. Reset mid-expansion aborts immediately, and the engine needs a new start.
- FSM states:
  - IDLE: on start, register round_key=key_in, rk_idx=0, rk_valid=1, and write table[0]. Set round counter rnd=1, clear keys_ready, go to EXPAND.
  - EXPAND: each cycle, with prev=round_key split as w0..w3:
    - temp = SubWord(RotWord(w3)) ^ rcon(rnd), where rcon comes from the aes_rcon instance with rndNo=rnd.
    - n0=w0^temp, n1=w1^n0, n2=w2^n1, n3=w3^n2.
    - Register round_key={n0,n1,n2,n3}, rk_idx=rnd, rk_valid=1, write table[rnd], then rnd+1.
    - When rnd==NR: assert done and set keys_ready for that same registered cycle, then return to IDLE.
- RotWord is a left byte rotate. SubWord is four combinational FIPS-197 S-box lookups.
- Cycle timing (start sampled at edge T):
  - Edges T..T+10 produce rk_idx 0..10, one per cycle, with rk_valid=1 on each.
  - busy=1 for the cycles following edges T..T+9.
  - After edge T+11: rk_valid=0, busy=0, done=0. round_key and rk_idx hold their last values.
- start while busy: ignored, with no restart and no effect.
- start in IDLE when keys_ready=1: restarts expansion and clears keys_ready on that edge.
- Read port: rd_key <= table[rd_idx] every cycle.
  - rd_idx > 10 returns 0.
  - A read and write to the same index on the same edge returns the old contents (read-before-write).
  - Reads during EXPAND are legal and return current table contents.
- XOR only; no arithmetic carries.

Test Plan:
- Reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> idx0 = key_in; idx1 = a0fafe1788542cb123a339392a6c7605; idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1, 10 cycles after the idx0 cycle; keys_ready=1 afterwards.
- After the run above, sweep rd_idx 0..15 -> rd_key matches the streamed keys one cycle later; indices 11..15 return 0.
- Pulse start again at idx4 of an expansion -> sequence continues unchanged to idx10; no restart, exactly one done pulse.
- Assert rst at idx6 -> all outputs 0 at once, table cleared, keys_ready=0. A new start with key 000102030405060708090a0b0c0d0e0f -> idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Assert start the cycle after done -> accepted: keys_ready drops, idx0 appears, full expansion repeats.
- Hold start high continuously -> back-to-back expansions, each exactly 11 valid cycles; start is accepted only in IDLE, one cycle after each done.
